i2c_reg_ctrl: RTL and testbench

I2C register-access controller that sequences the `i2c_bit_shift` byte engine to perform complete single-register write and random-read transactions. It accepts one request at a time from a user port, and on a tie between write and read requests the write wins. It breaks each transaction into a series of byte commands (`cmd`, `tx_data`, `work_en`), checks the slave ACK after every byte, and returns read data and error status to the user side. It sits between the system and `i2c_bit_shift`, one level above the bus-level bit sequencing.

---
 rtl/i2c_reg_ctrl.sv | 150 +++++++++++++++
 tb/tb_i2c_reg_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: sequences the i2c_bit_shift byte engine through complete
// single-register write and random-read transactions.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   wr_req, rd_req       user requests (write wins a tie), sampled in IDLE
//   dev_addr, reg_addr   7-bit slave address, register address
//   wr_data              byte to write
//   busy, done           transaction in progress / one-cycle end pulse
//   ack_err              slave NACKed an address or write byte
//   rd_data, rd_valid    read result / one-cycle pulse on a good read
//   cmd, tx_data         byte command and payload to the shifter
//   work_en              one-cycle start pulse per byte to the shifter
//   trans_done, ack_i    byte complete / slave ACK bit (0 = ACK)
//   rx_data              received byte from the shifter
module i2c_reg_ctrl #(
    parameter int ADDR_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [6:0]  dev_addr,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [5:0]  cmd,
    output logic        work_en,
    output logic [7:0]  tx_data,
    input  logic        trans_done,
    input  logic        ack_i,
    input  logic [7:0]  rx_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    localparam logic [2:0] WR_LAST = 3'(ADDR_BYTES + 1);
    localparam logic [2:0] RD_LAST = 3'(ADDR_BYTES + 2);

    state_t      state;
    logic        op_rd;
    logic [6:0]  dev_q;
    logic [15:0] reg_q;
    logic [7:0]  wdat_q;
    logic [2:0]  idx;
    logic [2:0]  last_idx;

    assign last_idx = op_rd ? RD_LAST : WR_LAST;

    // {cmd, tx_data} for byte i of the transaction
    function automatic logic [13:0] sched(
        input logic        rd,
        input logic [6:0]  dev,
        input logic [15:0] ra,
        input logic [7:0]  wd,
        input logic [2:0]  i
    );
        logic [13:0] b;
        if (i == 3'd0) begin
            b = {6'b000011, dev, 1'b0};
        end else if (i <= 3'(ADDR_BYTES)) begin
            b = {6'b000001,
                 (ADDR_BYTES == 2 && i == 3'd1) ? ra[15:8] : ra[7:0]};
        end else if (i == 3'(ADDR_BYTES + 1)) begin
            b = rd ? {6'b000011, dev, 1'b1} : {6'b001001, wd};
        end else begin
            b = {6'b101100, 8'h00};
        end
        return b;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_rd    <= 1'b0;
            dev_q    <= '0;
            reg_q    <= '0;
            wdat_q   <= '0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            cmd      <= '0;
            tx_data  <= '0;
            work_en  <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            work_en  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (wr_req || rd_req) begin
                        op_rd          <= !wr_req;
                        dev_q          <= dev_addr;
                        reg_q          <= reg_addr;
                        wdat_q         <= wr_data;
                        idx            <= '0;
                        ack_err        <= 1'b0;
                        {cmd, tx_data} <= sched(!wr_req, dev_addr,
                                                reg_addr, wr_data, 3'd0);
                        work_en        <= 1'b1;
                        busy           <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (trans_done) begin
                        if (idx == last_idx) begin
                            // the final read byte is master-NACKed,
                            // so ack_i carries no slave status there
                            if (op_rd) rd_data <= rx_data;
                            else       ack_err <= ack_i;
                            rd_valid <= op_rd;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else if (ack_i) begin
                            ack_err <= 1'b1;
                            done    <= 1'b1;
                            state   <= FINISH;
                        end else begin
                            idx            <= idx + 3'd1;
                            {cmd, tx_data} <= sched(op_rd, dev_q, reg_q,
                                                    wdat_q, idx + 3'd1);
                            work_en        <= 1'b1;
                            state          <= ISSUE;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: directed bench for i2c_reg_ctrl with ADDR_BYTES=1 (u0)
// and ADDR_BYTES=2 (u1), a shifter stand-in and a byte-level model.
module tb_i2c_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wr_req = '0;
    logic [1:0]  rd_req = '0;
    logic [6:0]  dev_addr = '0;
    logic [15:0] reg_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        trans_done, ack_i;
    logic [7:0]  rx_data;

    logic       busy0, done0, err0, rv0, we0;
    logic [7:0] rd0, tx0;
    logic [5:0] cmd0;
    logic       busy1, done1, err1, rv1, we1;
    logic [7:0] rd1, tx1;
    logic [5:0] cmd1;

    always #5 clk = ~clk;

    i2c_reg_ctrl #(.ADDR_BYTES(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req[0]), .rd_req(rd_req[0]),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
        .busy(busy0), .done(done0), .ack_err(err0),
        .rd_data(rd0), .rd_valid(rv0),
        .cmd(cmd0), .work_en(we0), .tx_data(tx0),
        .trans_done(trans_done), .ack_i(ack_i), .rx_data(rx_data)
    );

    i2c_reg_ctrl #(.ADDR_BYTES(2)) u1 (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req[1]), .rd_req(rd_req[1]),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
        .busy(busy1), .done(done1), .ack_err(err1),
        .rd_data(rd1), .rd_valid(rv1),
        .cmd(cmd1), .work_en(we1), .tx_data(tx1),
        .trans_done(trans_done), .ack_i(ack_i), .rx_data(rx_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // selected instance and its outputs
    bit sel = 1'b0;
    logic       busy_s, done_s, err_s, rv_s, we_s;
    logic [7:0] rd_s, tx_s;
    logic [5:0] cmd_s;
    logic       busy_o, done_o, we_o;
    assign busy_s = sel ? busy1 : busy0;
    assign done_s = sel ? done1 : done0;
    assign err_s  = sel ? err1  : err0;
    assign rv_s   = sel ? rv1   : rv0;
    assign we_s   = sel ? we1   : we0;
    assign rd_s   = sel ? rd1   : rd0;
    assign tx_s   = sel ? tx1   : tx0;
    assign cmd_s  = sel ? cmd1  : cmd0;
    assign busy_o = sel ? busy0 : busy1;
    assign done_o = sel ? done0 : done1;
    assign we_o   = sel ? we0   : we1;

    // model state
    logic [13:0] exp_q[$];
    logic [13:0] log_q[$];
    bit          op_rd;
    logic [7:0]  model_rd [2];
    bit          model_err [2];
    bit          td_pend, nack_hit, exp_next_we, prev_busy, prev_done;
    logic [7:0]  td_rx;
    int          done_cnt = 0;

    // shifter stand-in: trans_done a few cycles after each work_en
    int         nack_at = -1;
    logic [7:0] rx_val = '0;
    int         cnt;
    bit         pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trans_done <= 1'b0;
            ack_i      <= 1'b0;
            rx_data    <= '0;
            pend = 1'b0;
            cnt  = 0;
        end else begin
            trans_done <= 1'b0;
            if (we0 | we1) begin
                pend = 1'b1;
                cnt  = 3;
            end else if (pend) begin
                if (cnt == 1) begin
                    trans_done <= 1'b1;
                    ack_i      <= ((log_q.size() - 1) == nack_at);
                    rx_data    <= rx_val;
                    pend = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
        end
    end

    // per-cycle compare against the transaction model
    always @(negedge clk) begin
        bit rose, exp_we, exp_done, last;
        if (!rst_n) begin
            exp_q.delete();
            model_rd[0] = '0; model_rd[1] = '0;
            model_err[0] = 1'b0; model_err[1] = 1'b0;
            td_pend = 1'b0; nack_hit = 1'b0; exp_next_we = 1'b0;
            prev_busy = 1'b0; prev_done = 1'b0;
            chk("rst_out0", {busy0, done0, err0, rv0, we0, cmd0, tx0, rd0}, 0);
            chk("rst_out1", {busy1, done1, err1, rv1, we1, cmd1, tx1, rd1}, 0);
        end else begin
            rose = busy_s && !prev_busy;
            if (rose) begin
                model_err[sel] = 1'b0;
                nack_hit = 1'b0;
            end
            exp_we   = rose || (td_pend && exp_next_we);
            exp_done = td_pend && !exp_next_we;
            chk("work_en", we_s, exp_we);
            chk("done", done_s, exp_done);
            if (prev_done) chk("busy_fall", busy_s, 0);
            if (we_s) begin
                log_q.push_back({cmd_s, tx_s});
                chk("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("byte", {cmd_s, tx_s}, exp_q.pop_front());
            end
            if (done_s) begin
                if (op_rd && !nack_hit) model_rd[sel] = td_rx;
                model_err[sel] = nack_hit;
                chk("rd_valid", rv_s, op_rd && !nack_hit);
                if (!nack_hit) chk("all_bytes", exp_q.size(), 0);
                exp_q.delete();
                done_cnt++;
            end else begin
                chk("rd_valid_idle", rv_s, 0);
            end
            chk("ack_err", err_s, model_err[sel]);
            chk("rd_data", rd_s, model_rd[sel]);
            chk("other_idle", {busy_o, we_o, done_o}, 0);
            td_pend = trans_done;
            if (trans_done) begin
                last = (exp_q.size() == 0);
                if (ack_i && !(last && op_rd)) nack_hit = 1'b1;
                exp_next_we = !last && !ack_i;
                td_rx = rx_data;
            end
            prev_busy = busy_s;
            prev_done = done_s;
        end
    end

    task automatic build(input bit ab2, input bit w, input logic [6:0] d,
                         input logic [15:0] ra, input logic [7:0] wd);
        op_rd = !w;
        exp_q.delete();
        exp_q.push_back({6'h03, d, 1'b0});
        if (ab2) exp_q.push_back({6'h01, ra[15:8]});
        exp_q.push_back({6'h01, ra[7:0]});
        if (op_rd) begin
            exp_q.push_back({6'h03, d, 1'b1});
            exp_q.push_back({6'h2C, 8'h00});
        end else begin
            exp_q.push_back({6'h09, wd});
        end
    endtask

    task automatic request(input bit inst, input bit w, input bit r,
                           input logic [6:0] d, input logic [15:0] ra,
                           input logic [7:0] wd);
        bit ok;
        @(negedge clk);
        dev_addr = d; reg_addr = ra; wr_data = wd;
        wr_req[inst] = w; rd_req[inst] = r;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy_s) begin ok = 1; break; end
        end
        chk("accept", ok, 1);
        wr_req = '0; rd_req = '0;
    endtask

    task automatic run(input bit inst, input bit w, input bit r,
                       input logic [6:0] d, input logic [15:0] ra,
                       input logic [7:0] wd, input int nack,
                       input logic [7:0] rx, input bit poke);
        bit ok;
        sel = inst;
        log_q.delete();
        nack_at = nack;
        rx_val = rx;
        build(inst, w, d, ra, wd);
        request(inst, w, r, d, ra, wd);
        if (poke) begin
            repeat (2) @(negedge clk);
            rd_req[inst] = 1'b1;
            wr_req[inst] = 1'b1;
            repeat (3) @(negedge clk);
            rd_req = '0;
            wr_req = '0;
        end
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (done_s) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("done_seen", ok, 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // write, 1 address byte
        run(0, 1, 0, 7'h50, 16'h0010, 8'hA5, -1, 8'h00, 0);
        chk("wr1_n", log_q.size(), 3);
        chk("wr1_b0", log_q[0], {6'h03, 8'hA0});
        chk("wr1_b1", log_q[1], {6'h01, 8'h10});
        chk("wr1_b2", log_q[2], {6'h09, 8'hA5});
        chk("wr1_err", err0, 0);

        // read, 2 address bytes
        run(1, 0, 1, 7'h68, 16'h1234, 8'h00, -1, 8'h3C, 0);
        chk("rd2_n", log_q.size(), 5);
        chk("rd2_b0", log_q[0], {6'h03, 8'hD0});
        chk("rd2_b1", log_q[1], {6'h01, 8'h12});
        chk("rd2_b2", log_q[2], {6'h01, 8'h34});
        chk("rd2_b3", log_q[3], {6'h03, 8'hD1});
        chk("rd2_b4", log_q[4], {6'h2C, 8'h00});
        chk("rd2_data", rd1, 8'h3C);

        // address NACK, write and read
        run(0, 1, 0, 7'h22, 16'h0001, 8'h5A, 0, 8'h00, 0);
        chk("nak_w_n", log_q.size(), 1);
        chk("nak_w_b0", log_q[0], {6'h03, 8'h44});
        chk("nak_w_err", err0, 1);
        run(1, 0, 1, 7'h22, 16'hBEEF, 8'h00, 0, 8'h99, 0);
        chk("nak_r_n", log_q.size(), 1);
        chk("nak_r_err", err1, 1);
        chk("nak_r_hold", rd1, 8'h3C);

        // NACK on the repeated start of a read
        run(1, 0, 1, 7'h41, 16'hA55A, 8'h00, 3, 8'h77, 0);
        chk("nak_rs_n", log_q.size(), 4);
        chk("nak_rs_err", err1, 1);

        // NACK on the final write byte
        run(0, 1, 0, 7'h0F, 16'h00C3, 8'h66, 2, 8'h00, 0);
        chk("nak_wd_n", log_q.size(), 3);
        chk("nak_wd_err", err0, 1);

        // tie, then requests while busy
        ok = 1'b1;
        run(0, 1, 1, 7'h3A, 16'h0055, 8'h77, -1, 8'h00, 1);
        chk("tie_n", log_q.size(), 3);
        chk("tie_b2", log_q[2], {6'h09, 8'h77});
        repeat (10) @(negedge clk);
        chk("tie_no_second", log_q.size(), 3);
        chk("tie_idle", busy0, 0);

        // reset in WAIT of the second byte
        sel = 0;
        log_q.delete();
        nack_at = -1;
        build(0, 1, 7'h11, 16'h0022, 8'h33);
        request(0, 1, 0, 7'h11, 16'h0022, 8'h33);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (log_q.size() == 2) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("rst_second_byte", ok, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {busy0, we0, cmd0, tx0}, 0);
        repeat (3) @(negedge clk);
        chk("rst_no_we", log_q.size(), 2);
        rst_n = 1'b1;
        run(0, 1, 0, 7'h11, 16'h0022, 8'h33, -1, 8'h00, 0);
        chk("post_rst_n", log_q.size(), 3);
        chk("post_rst_b0", log_q[0], {6'h03, 8'h22});
        chk("post_rst_err", err0, 0);
        chk("done_total", done_cnt, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
